// File: rtl/lvds_video_rx.sv
// rtl/lvds_video_rx.sv - 7:1 LVDS video receiver: word alignment, lock tracking and RGB666 unpack
module lvds_video_rx #(
    parameter logic [6:0] CLK_PATTERN = 7'b1100011,
    parameter int         LOCK_COUNT  = 4,
    parameter int         MISS_LIMIT  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lane_clk,
    input  logic       lane1,
    input  logic       lane2,
    input  logic       lane3,
    output logic       pix_valid,
    output logic [7:0] Red,
    output logic [7:0] Green,
    output logic [7:0] Blue,
    output logic       HSync,
    output logic       VSync,
    output logic       DataEnable,
    output logic       locked,
    output logic [7:0] err_cnt
);

    typedef enum logic {HUNT, LOCKED} state_t;

    localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);
    localparam logic [3:0] MISS_C = 4'(MISS_LIMIT);

    state_t      state_q, state_d;
    logic [6:0]  sr_clk_q, sr_clk_d;
    logic [6:0]  sr1_q, sr1_d;
    logic [6:0]  sr2_q, sr2_d;
    logic [6:0]  sr3_q, sr3_d;
    logic [2:0]  phase_q, phase_d;
    logic [3:0]  hit_cnt_q, hit_cnt_d;
    logic [3:0]  miss_cnt_q, miss_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        pix_valid_q, pix_valid_d;
    logic [5:0]  red_q, red_d;
    logic [5:0]  green_q, green_d;
    logic [5:0]  blue_q, blue_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic        hit;

    assign hit = (sr_clk_q == CLK_PATTERN);

    always_comb begin
        state_d     = state_q;
        sr_clk_d    = {sr_clk_q[5:0], lane_clk};
        sr1_d       = {sr1_q[5:0], lane1};
        sr2_d       = {sr2_q[5:0], lane2};
        sr3_d       = {sr3_q[5:0], lane3};
        phase_d     = (phase_q == 3'd6) ? 3'd0 : phase_q + 3'd1;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_cnt_d   = err_cnt_q;
        pix_valid_d = 1'b0;
        red_d       = red_q;
        green_d     = green_q;
        blue_d      = blue_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        de_d        = de_q;

        case (state_q)
            HUNT: begin
                // Each hit re-anchors the word phase, so a chain is aligned only at 7-clk spacing
                if (hit) begin
                    phase_d   = 3'd0;
                    hit_cnt_d = (phase_q == 3'd6) ? hit_cnt_q + 4'd1 : 4'd1;
                    if (hit_cnt_d >= LOCK_C) begin
                        state_d    = LOCKED;
                        miss_cnt_d = 4'd0;
                    end
                end
            end
            LOCKED: begin
                if (phase_q == 3'd6) begin
                    if (hit) begin
                        miss_cnt_d  = 4'd0;
                        pix_valid_d = 1'b1;
                        red_d   = {sr1_q[1], sr1_q[2], sr1_q[3], sr1_q[4], sr1_q[5], sr1_q[6]};
                        green_d = {sr2_q[2], sr2_q[3], sr2_q[4], sr2_q[5], sr2_q[6], sr1_q[0]};
                        blue_d  = {sr3_q[3], sr3_q[4], sr3_q[5], sr3_q[6], sr2_q[0], sr2_q[1]};
                        hs_d    = sr3_q[2];
                        vs_d    = sr3_q[1];
                        de_d    = sr3_q[0];
                    end else begin
                        miss_cnt_d = miss_cnt_q + 4'd1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        if (miss_cnt_d >= MISS_C) begin
                            state_d   = HUNT;
                            hit_cnt_d = 4'd0;
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= HUNT;
            sr_clk_q    <= 7'd0;
            sr1_q       <= 7'd0;
            sr2_q       <= 7'd0;
            sr3_q       <= 7'd0;
            phase_q     <= 3'd0;
            hit_cnt_q   <= 4'd0;
            miss_cnt_q  <= 4'd0;
            err_cnt_q   <= 8'd0;
            pix_valid_q <= 1'b0;
            red_q       <= 6'd0;
            green_q     <= 6'd0;
            blue_q      <= 6'd0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_clk_q    <= sr_clk_d;
            sr1_q       <= sr1_d;
            sr2_q       <= sr2_d;
            sr3_q       <= sr3_d;
            phase_q     <= phase_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_cnt_q   <= err_cnt_d;
            pix_valid_q <= pix_valid_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign Red        = {2'b00, red_q};
    assign Green      = {2'b00, green_q};
    assign Blue       = {2'b00, blue_q};
    assign HSync      = hs_q;
    assign VSync      = vs_q;
    assign DataEnable = de_q;
    assign locked     = (state_q == LOCKED);
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_lvds_video_rx.sv
// tb/tb_lvds_video_rx.sv - randomized bench for lvds_video_rx against a cycle-indexed reference model
module tb_lvds_video_rx;

    localparam logic [6:0] PAT = 7'b1100011;
    localparam int LOCK_N = 4;
    localparam int MISS_N = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       lane_clk, lane1, lane2, lane3;
    logic       pix_valid;
    logic [7:0] Red, Green, Blue;
    logic       HSync, VSync, DataEnable;
    logic       locked;
    logic [7:0] err_cnt;

    lvds_video_rx dut (
        .clk(clk), .rst(rst), .lane_clk(lane_clk), .lane1(lane1), .lane2(lane2), .lane3(lane3),
        .pix_valid(pix_valid), .Red(Red), .Green(Green), .Blue(Blue), .HSync(HSync),
        .VSync(VSync), .DataEnable(DataEnable), .locked(locked), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: word phase is (edge - anchor) mod 7, history is the last 7 lane samples
    int         edge_n = 0;
    int         anchor = 1;
    bit [6:0]   h_clk, h1, h2, h3;
    bit         m_locked, m_pv;
    int         m_hits, m_miss, m_err;
    bit [7:0]   m_r, m_g, m_b;
    bit         m_hs, m_vs, m_de;

    function automatic void model_edge(bit rstn, bit lc, bit l1, bit l2, bit l3);
        bit hit;
        int ph;
        edge_n++;
        m_pv = 0;
        if (!rstn) begin
            h_clk = 0; h1 = 0; h2 = 0; h3 = 0;
            m_locked = 0; m_hits = 0; m_miss = 0; m_err = 0;
            m_r = 0; m_g = 0; m_b = 0; m_hs = 0; m_vs = 0; m_de = 0;
            anchor = edge_n + 1;
            return;
        end
        hit = (h_clk == PAT);
        ph  = (edge_n - anchor) % 7;
        if (!m_locked) begin
            if (hit) begin
                m_hits = (ph == 6) ? m_hits + 1 : 1;
                anchor = edge_n + 1;
                if (m_hits >= LOCK_N) begin
                    m_locked = 1;
                    m_miss = 0;
                end
            end
        end else if (ph == 6) begin
            if (hit) begin
                m_miss = 0;
                m_pv = 1;
                m_r = 0; m_g = 0; m_b = 0;
                for (int k = 0; k < 6; k++) m_r[k] = h1[6-k];
                m_g[0] = h1[0];
                for (int k = 1; k < 6; k++) m_g[k] = h2[7-k];
                m_b[0] = h2[1];
                m_b[1] = h2[0];
                for (int k = 2; k < 6; k++) m_b[k] = h3[8-k];
                m_hs = h3[2]; m_vs = h3[1]; m_de = h3[0];
            end else begin
                m_miss++;
                if (m_err < 255) m_err++;
                if (m_miss >= MISS_N) begin
                    m_locked = 0;
                    m_hits = 0;
                end
            end
        end
        h_clk = {h_clk[5:0], lc};
        h1 = {h1[5:0], l1};
        h2 = {h2[5:0], l2};
        h3 = {h3[5:0], l3};
    endfunction

    int  lock_edge, first_pv_edge;
    bit  prev_locked;

    task automatic tick(input bit rstn, input bit lc, input bit l1, input bit l2, input bit l3);
        rst = rstn; lane_clk = lc; lane1 = l1; lane2 = l2; lane3 = l3;
        @(posedge clk);
        model_edge(rstn, lc, l1, l2, l3);
        @(negedge clk);
        check("locked", 32'(locked), 32'(m_locked));
        check("pix_valid", 32'(pix_valid), 32'(m_pv));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
        check("pixel", {5'd0, Red, Green, Blue, HSync, VSync, DataEnable},
              {5'd0, m_r, m_g, m_b, m_hs, m_vs, m_de});
        if (locked && !prev_locked && lock_edge < 0) lock_edge = edge_n;
        if (pix_valid && first_pv_edge < 0) first_pv_edge = edge_n;
        prev_locked = locked;
    endtask

    task automatic send_word(input bit [6:0] cw, input bit [5:0] r, input bit [5:0] g,
                             input bit [5:0] b, input bit hs, input bit vs, input bit de);
        bit [6:0] w1, w2, w3;
        w1 = {r[0], r[1], r[2], r[3], r[4], r[5], g[0]};
        w2 = {g[1], g[2], g[3], g[4], g[5], b[0], b[1]};
        w3 = {b[2], b[3], b[4], b[5], hs, vs, de};
        for (int i = 0; i < 7; i++) tick(1'b1, cw[6-i], w1[6-i], w2[6-i], w3[6-i]);
    endtask

    bit [5:0] lr, lg, lb;
    bit       lhs, lvs, lde;

    task automatic send_rand(input bit [6:0] cw);
        lr = 6'($urandom); lg = 6'($urandom); lb = 6'($urandom);
        lhs = 1'($urandom); lvs = 1'($urandom); lde = 1'($urandom);
        send_word(cw, lr, lg, lb, lhs, lvs, lde);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++)
            tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        lock_edge = -1;
        first_pv_edge = -1;
        prev_locked = 0;
    endtask

    bit [5:0] pr, pg, pb;
    bit       phs, pvs, pde;

    initial begin
        // 1: reset with random lanes
        do_reset(5);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_pixel", {5'd0, Red, Green, Blue, HSync, VSync, DataEnable}, 32'd0);

        // 2: lock on fixed words
        for (int i = 0; i < 6; i++) send_word(PAT, 6'h2A, 6'h15, 6'h33, 1'b1, 1'b0, 1'b1);
        check("lock_up", 32'(locked), 32'd1);
        check("pv_delay", 32'(first_pv_edge - lock_edge), 32'd7);
        check("red_fixed", 32'(Red), 32'h2A);
        check("green_fixed", 32'(Green), 32'h15);
        check("blue_fixed", 32'(Blue), 32'h33);
        check("sync_fixed", {29'd0, HSync, VSync, DataEnable}, 32'b101);

        // 3: one-bit slip, relock at new phase
        for (int i = 0; i < 3; i++) send_rand(PAT);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) send_rand(PAT);
        check("slip_err", 32'(err_cnt), 32'd2);
        check("slip_relock", 32'(locked), 32'd1);
        pr = lr; pg = lg; pb = lb; phs = lhs; pvs = lvs; pde = lde;
        send_rand(PAT);
        check("slip_data", {5'd0, Red, Green, Blue, HSync, VSync, DataEnable},
              {5'd0, 2'b00, pr, 2'b00, pg, 2'b00, pb, phs, pvs, pde});

        // 4: single corrupted clock word
        do_reset(2);
        for (int i = 0; i < 6; i++) send_rand(PAT);
        send_rand(7'b0000000);
        for (int i = 0; i < 3; i++) send_rand(PAT);
        check("glitch_err", 32'(err_cnt), 32'd1);
        check("glitch_locked", 32'(locked), 32'd1);

        // 5: hits spaced 8 clk apart never lock
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            send_rand(PAT);
            tick(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        end
        check("false_hunt", 32'(locked), 32'd0);

        // 6: reset mid-word while locked
        do_reset(2);
        for (int i = 0; i < 6; i++) send_rand(PAT);
        send_rand(7'b0101010);
        send_rand(PAT);
        for (int i = 0; i < 3; i++) tick(1'b1, PAT[6-i], 1'($urandom), 1'($urandom), 1'($urandom));
        do_reset(1);
        check("mid_rst_locked", 32'(locked), 32'd0);
        check("mid_rst_err", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 4; i++) send_rand(PAT);
        check("relock_not_early", 32'(locked), 32'd0);
        for (int i = 0; i < 2; i++) send_rand(PAT);
        check("relock", 32'(locked), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
